// File: rtl/mod_led_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_led_seq_pkg                                                            |
// | Shared mode encodings, register offsets and default timer width.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mod_led_seq_pkg;

    localparam int TW_DEFAULT = 24;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTL   = 2'd2,
        MODE_ROTR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        REG_PATTERN = 2'd0,
        REG_CTRL    = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_STEPS   = 2'd3
    } reg_e;

endpackage
`default_nettype wire

// File: rtl/mod_led_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_led_seq_if                                                             |
// | Instruction/data bus bundle seen by the LED sequencer.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mod_led_seq_if;
    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [1:0]  drw;
    logic [31:0] din;
    logic [31:0] iout;
    logic [31:0] dout;

    modport master (
        output ie, de, iaddr, daddr, drw, din,
        input  iout, dout
    );

    modport slave (
        input  ie, de, iaddr, daddr, drw, din,
        output iout, dout
    );
endinterface
`default_nettype wire

// File: rtl/mod_led_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_led_seq_timer                                                          |
// | Free-running period counter producing a one-edge tick; period 0 freezes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_led_seq_timer
    import mod_led_seq_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          clr,
    input  wire [TW-1:0] period,
    output logic         tick
);

    logic [TW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (period != '0) && (r_cnt == period - TW'(1));
    // A clear on the same edge restarts the period, so it must also swallow the tick.
    assign tick   = w_last && !clr && !rst;

    always_ff @(negedge clk) begin
        if (rst || clr || (period == '0) || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_led_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_led_seq                                                                |
// | Bus-programmable LED sequencer: static, blink and rotate modes.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mod_led_seq
    import mod_led_seq_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  wire          clk,
    input  wire          rst,
    mod_led_seq_if.slave bus,
    output logic [7:0]   leds
);

    logic [7:0]    r_pattern;
    mode_e         r_mode;
    logic [TW-1:0] r_period;
    logic [15:0]   r_steps;
    logic          r_phase;
    logic [7:0]    r_leds;

    logic          w_wr;
    logic          w_wr_pattern;
    logic          w_wr_ctrl;
    logic          w_wr_period;
    logic          w_tick;
    logic [31:0]   w_dout;
    logic          w_unused;

    assign w_wr         = bus.de && bus.drw[0];
    assign w_wr_pattern = w_wr && (bus.daddr[3:2] == REG_PATTERN);
    assign w_wr_ctrl    = w_wr && (bus.daddr[3:2] == REG_CTRL);
    assign w_wr_period  = w_wr && (bus.daddr[3:2] == REG_PERIOD);

    mod_led_seq_timer #(
        .TW (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_wr_ctrl || w_wr_period),
        .period (r_period),
        .tick   (w_tick)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            r_pattern <= 8'hFF;
            r_mode    <= MODE_STATIC;
            r_period  <= '0;
            r_steps   <= '0;
            r_phase   <= 1'b0;
            r_leds    <= 8'hFF;
        end else begin
            r_leds <= ((r_mode == MODE_BLINK) && r_phase) ? 8'h00 : r_pattern;

            if (w_tick) begin
                r_steps <= r_steps + 16'd1;
                case (r_mode)
                    MODE_BLINK: r_phase   <= ~r_phase;
                    MODE_ROTL:  r_pattern <= {r_pattern[6:0], r_pattern[7]};
                    MODE_ROTR:  r_pattern <= {r_pattern[0], r_pattern[7:1]};
                    default:    ;
                endcase
            end

            // Placed after the tick update so a colliding bus write wins.
            if (w_wr_pattern) begin
                r_pattern <= bus.din[7:0];
            end
            if (w_wr_ctrl) begin
                r_mode  <= mode_e'(bus.din[1:0]);
                r_phase <= 1'b0;
            end
            if (w_wr_period) begin
                r_period <= bus.din[TW-1:0];
                r_phase  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_dout = 32'h0;
        case (bus.daddr[3:2])
            REG_PATTERN: w_dout = {24'h0, r_pattern};
            REG_CTRL:    w_dout = {30'h0, r_mode};
            REG_PERIOD:  w_dout = 32'(r_period);
            REG_STEPS:   w_dout = {16'h0, r_steps};
            default:     w_dout = 32'h0;
        endcase
    end

    assign bus.dout = w_dout;
    assign bus.iout = 32'h0;
    assign leds     = r_leds;

    assign w_unused = ^{bus.ie, bus.iaddr, bus.daddr[31:4], bus.daddr[1:0],
                        bus.drw[1], bus.din};

endmodule
`default_nettype wire

// File: tb/tb_mod_led_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mod_led_seq                                                             |
// | Directed self-checking bench for the LED sequencer.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mod_led_seq;
    import mod_led_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  leds;
    int          checks;
    int          errors;
    logic [31:0] v;

    mod_led_seq_if bus ();

    mod_led_seq #(
        .TW (24)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .leds (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active edge is negedge; inputs change and outputs are sampled 1ns after it.
    task automatic edge_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        bus.de    = 1'b1;
        bus.drw   = 2'b01;
        bus.daddr = {28'h0, idx, 2'b00};
        bus.din   = data;
        edge_n(1);
        bus.de    = 1'b0;
        bus.drw   = 2'b00;
        bus.din   = 32'h0;
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [31:0] val);
        bus.daddr = {28'h0, idx, 2'b00};
        #1;
        val = bus.dout;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        edge_n(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_r [4];
        exp_r = '{32'hFF, 32'h0, 32'h0, 32'h0};
        reset_dut();
        checks++;
        if (leds !== 8'hFF) begin
            errors++; $display("FAIL reset_leds: got %h expected %h", leds, 8'hFF);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            checks++;
            if (v !== exp_r[i]) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, v, exp_r[i]);
            end
        end
        edge_n(100);
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL reset_steps_idle: got %h expected %h", v, 32'h0);
        end
        checks++;
        if (bus.iout !== 32'h0) begin
            errors++; $display("FAIL iout_reset: got %h expected %h", bus.iout, 32'h0);
        end
    endtask

    task automatic test_rotl();
        logic [7:0] exp_p [3];
        exp_p = '{8'h02, 8'h04, 8'h08};
        reset_dut();
        bus_write(REG_PATTERN, 32'h01);
        bus_write(REG_PERIOD, 32'h4);
        bus_write(REG_CTRL, 32'h2);
        for (int i = 0; i < 3; i++) begin
            edge_n(4);
            read_reg(REG_PATTERN, v);
            checks++;
            if (v !== {24'h0, exp_p[i]}) begin
                errors++; $display("FAIL rotl_step%0d: got %h expected %h", i, v, exp_p[i]);
            end
        end
        edge_n(20);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'h01) begin
            errors++; $display("FAIL rotl_wrap: got %h expected %h", v, 32'h01);
        end
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h8) begin
            errors++; $display("FAIL rotl_steps: got %h expected %h", v, 32'h8);
        end
        checks++;
        if (leds !== 8'h80) begin
            errors++; $display("FAIL rotl_leds_lag: got %h expected %h", leds, 8'h80);
        end
    endtask

    task automatic test_blink();
        // leds after each edge following the CTRL write (ticks at edges 3, 6, 9)
        logic [7:0] exp_l [10];
        exp_l = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        reset_dut();
        bus_write(REG_PATTERN, 32'hA5);
        bus_write(REG_PERIOD, 32'h3);
        bus_write(REG_CTRL, 32'h1);
        for (int i = 0; i < 10; i++) begin
            edge_n(1);
            checks++;
            if (leds !== exp_l[i]) begin
                errors++; $display("FAIL blink_edge%0d: got %h expected %h", i + 1, leds, exp_l[i]);
            end
        end
        bus_write(REG_CTRL, 32'h0);
        checks++;
        if (leds !== 8'h00) begin
            errors++; $display("FAIL blink_exit_same_edge: got %h expected %h", leds, 8'h00);
        end
        edge_n(1);
        checks++;
        if (leds !== 8'hA5) begin
            errors++; $display("FAIL blink_exit_next_edge: got %h expected %h", leds, 8'hA5);
        end
    endtask

    task automatic test_collision();
        reset_dut();
        bus_write(REG_PATTERN, 32'h0F);
        bus_write(REG_PERIOD, 32'h2);
        bus_write(REG_CTRL, 32'h3);
        edge_n(2);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'h87) begin
            errors++; $display("FAIL rotr_first_tick: got %h expected %h", v, 32'h87);
        end
        edge_n(1);
        bus_write(REG_PATTERN, 32'h80);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'h80) begin
            errors++; $display("FAIL collision_load: got %h expected %h", v, 32'h80);
        end
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL collision_steps: got %h expected %h", v, 32'h2);
        end
        edge_n(1);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'h80) begin
            errors++; $display("FAIL collision_hold: got %h expected %h", v, 32'h80);
        end
        edge_n(1);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'h40) begin
            errors++; $display("FAIL collision_rotate: got %h expected %h", v, 32'h40);
        end
    endtask

    task automatic test_boundaries();
        reset_dut();
        bus_write(REG_PERIOD, 32'h1);
        edge_n(65535);
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'hFFFF) begin
            errors++; $display("FAIL steps_full: got %h expected %h", v, 32'hFFFF);
        end
        edge_n(1);
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL steps_wrap: got %h expected %h", v, 32'h0);
        end
        bus_write(REG_PATTERN, 32'h01);
        bus_write(REG_CTRL, 32'h2);
        edge_n(3);
        rst = 1'b1;
        edge_n(1);
        rst = 1'b0;
        checks++;
        if (leds !== 8'hFF) begin
            errors++; $display("FAIL midrst_leds: got %h expected %h", leds, 8'hFF);
        end
        edge_n(5);
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++; $display("FAIL midrst_pattern: got %h expected %h", v, 32'hFF);
        end
        read_reg(REG_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL midrst_ctrl: got %h expected %h", v, 32'h0);
        end
        read_reg(REG_PERIOD, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL midrst_period: got %h expected %h", v, 32'h0);
        end
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL midrst_steps: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_bus_hygiene();
        reset_dut();
        bus.de    = 1'b0;
        bus.drw   = 2'b01;
        bus.daddr = {28'h0, REG_PATTERN, 2'b00};
        bus.din   = 32'h55;
        edge_n(1);
        bus.de    = 1'b1;
        bus.drw   = 2'b10;
        bus.daddr = {28'h0, REG_CTRL, 2'b00};
        bus.din   = 32'h3;
        edge_n(1);
        bus.de    = 1'b0;
        bus.drw   = 2'b00;
        read_reg(REG_PATTERN, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++; $display("FAIL hyg_de0: got %h expected %h", v, 32'hFF);
        end
        read_reg(REG_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL hyg_readstrobe: got %h expected %h", v, 32'h0);
        end
        bus_write(REG_STEPS, 32'h1234);
        read_reg(REG_STEPS, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL hyg_steps_ro: got %h expected %h", v, 32'h0);
        end
        bus_write(REG_PERIOD, 32'hFFFF_FFFF);
        read_reg(REG_PERIOD, v);
        checks++;
        if (v !== 32'h00FF_FFFF) begin
            errors++; $display("FAIL hyg_period_width: got %h expected %h", v, 32'h00FF_FFFF);
        end
        checks++;
        if (bus.iout !== 32'h0) begin
            errors++; $display("FAIL iout_end: got %h expected %h", bus.iout, 32'h0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.ie    = 1'b0;
        bus.de    = 1'b0;
        bus.iaddr = 32'h0;
        bus.daddr = 32'h0;
        bus.drw   = 2'b00;
        bus.din   = 32'h0;
        test_reset();
        test_rotl();
        test_blink();
        test_collision();
        test_boundaries();
        test_bus_hygiene();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
